// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-requester arbiter in front of a single-port synchronous data
//            RAM. One transaction in flight at a time, round-robin or fixed
//            priority grant, read latency sequenced with a small down-counter.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // port 0: CPU data port
  input  logic                  i_m0_req,
  input  logic                  i_m0_write,
  input  logic [ADDR_W-1:0]     i_m0_addr,
  input  logic [DATA_W/8-1:0]   i_m0_byteen,
  input  logic [DATA_W-1:0]     i_m0_wdata,
  output logic                  o_m0_ready,
  output logic                  o_m0_rvalid,
  output logic [DATA_W-1:0]     o_m0_rdata,
  // port 1: secondary master (loader / DMA)
  input  logic                  i_m1_req,
  input  logic                  i_m1_write,
  input  logic [ADDR_W-1:0]     i_m1_addr,
  input  logic [DATA_W/8-1:0]   i_m1_byteen,
  input  logic [DATA_W-1:0]     i_m1_wdata,
  output logic                  o_m1_ready,
  output logic                  o_m1_rvalid,
  output logic [DATA_W-1:0]     o_m1_rdata,
  // RAM side
  output logic [ADDR_W-1:0]     o_ram_address,
  output logic [DATA_W/8-1:0]   o_ram_byteena,
  output logic                  o_ram_wren,
  output logic [DATA_W-1:0]     o_ram_data,
  input  logic [DATA_W-1:0]     i_ram_q
);

  localparam int         c_BE_W     = DATA_W / 8;
  // RD_LATENCY is at most 3, so the wait counter never needs more than 2 bits
  localparam logic [1:0] c_CNT_INIT = 2'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant;
  logic                r_sel;
  logic                r_write;
  logic [1:0]          r_cnt;

  logic                w_any_req;
  logic                w_win;
  logic                w_capture;
  logic                w_sel_write;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [c_BE_W-1:0]   w_sel_be;
  logic [DATA_W-1:0]   w_sel_wdata;

  logic                r_m0_ready;
  logic                r_m1_ready;
  logic                r_m0_rvalid;
  logic                r_m1_rvalid;
  logic [DATA_W-1:0]   r_m0_rdata;
  logic [DATA_W-1:0]   r_m1_rdata;
  logic [ADDR_W-1:0]   r_ram_address;
  logic [c_BE_W-1:0]   r_ram_byteena;
  logic                r_ram_wren;
  logic [DATA_W-1:0]   r_ram_data;

  // Pick the winner (0 or 1) among the current requesters and mux its fields
  always_comb begin
    w_any_req = i_m0_req | i_m1_req;
    if (FIXED_PRIO != 0) begin
      w_win = ~i_m0_req;
    end else if (i_m0_req && i_m1_req) begin
      // tie: the port that did not win last time goes next
      w_win = ~r_last_grant;
    end else begin
      w_win = ~i_m0_req;
    end
    w_sel_write = w_win ? i_m1_write  : i_m0_write;
    w_sel_addr  = w_win ? i_m1_addr   : i_m0_addr;
    w_sel_be    = w_win ? i_m1_byteen : i_m0_byteen;
    w_sel_wdata = w_win ? i_m1_wdata  : i_m0_wdata;
  end

  // Next-state logic; flags the cycle in which RAM read data is valid
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = r_write ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_state_nxt = S_IDLE;
          w_capture   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Register the granted request, drive the RAM, and produce ready/rvalid pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant  <= 1'b1;
      r_sel         <= 1'b0;
      r_write       <= 1'b0;
      r_cnt         <= 2'd0;
      r_m0_ready    <= 1'b0;
      r_m1_ready    <= 1'b0;
      r_m0_rvalid   <= 1'b0;
      r_m1_rvalid   <= 1'b0;
      r_m0_rdata    <= '0;
      r_m1_rdata    <= '0;
      r_ram_address <= '0;
      r_ram_byteena <= '0;
      r_ram_wren    <= 1'b0;
      r_ram_data    <= '0;
    end else begin
      r_m0_ready  <= 1'b0;
      r_m1_ready  <= 1'b0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel         <= w_win;
            r_last_grant  <= w_win;
            r_write       <= w_sel_write;
            r_ram_address <= w_sel_addr;
            r_ram_byteena <= w_sel_be;
            r_ram_wren    <= w_sel_write;
            r_ram_data    <= w_sel_write ? w_sel_wdata : '0;
            r_m0_ready    <= ~w_win;
            r_m1_ready    <= w_win;
          end
        end
        S_ISSUE: begin
          r_ram_wren <= 1'b0;
          r_cnt      <= c_CNT_INIT;
        end
        S_WAIT: begin
          if (r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
        end
        default: ;
      endcase
      if (w_capture) begin
        if (r_sel) begin
          r_m1_rdata  <= i_ram_q;
          r_m1_rvalid <= 1'b1;
        end else begin
          r_m0_rdata  <= i_ram_q;
          r_m0_rvalid <= 1'b1;
        end
      end
    end
  end

  assign o_m0_ready    = r_m0_ready;
  assign o_m1_ready    = r_m1_ready;
  assign o_m0_rvalid   = r_m0_rvalid;
  assign o_m1_rvalid   = r_m1_rvalid;
  assign o_m0_rdata    = r_m0_rdata;
  assign o_m1_rdata    = r_m1_rdata;
  assign o_ram_address = r_ram_address;
  assign o_ram_byteena = r_ram_byteena;
  assign o_ram_wren    = r_ram_wren;
  assign o_ram_data    = r_ram_data;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter. Three instances:
//            d0 = round-robin / latency 1, d1 = fixed priority / latency 1,
//            d2 = round-robin / latency 3, each with its own RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;

  logic        m0_req[3], m0_write[3], m1_req[3], m1_write[3];
  logic [9:0]  m0_addr[3], m1_addr[3];
  logic [3:0]  m0_be[3], m1_be[3];
  logic [31:0] m0_wdata[3], m1_wdata[3];
  logic        m0_ready[3], m1_ready[3], m0_rvalid[3], m1_rvalid[3];
  logic [31:0] m0_rdata[3], m1_rdata[3];
  logic [9:0]  ram_address[3];
  logic [3:0]  ram_byteena[3];
  logic        ram_wren[3];
  logic [31:0] ram_data[3];
  logic [31:0] ram_q[3];

  int vectors = 0;
  int miscompares = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // power-up RAM content, distinct per instance and address
  function automatic logic [31:0] init_word(int k, logic [9:0] a);
    return {8'(k + 1), 8'hC3, 6'd0, a};
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int L = (k == 2) ? 3 : 1;
    // stored as content XOR init_word so the 2-state zero default means "power-up content"
    bit [31:0] mem [1024];
    bit [31:0] pipe [L];

    dmem_arbiter #(
      .ADDR_W(10), .DATA_W(32), .RD_LATENCY(L), .FIXED_PRIO((k == 1) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_m0_req(m0_req[k]), .i_m0_write(m0_write[k]), .i_m0_addr(m0_addr[k]),
      .i_m0_byteen(m0_be[k]), .i_m0_wdata(m0_wdata[k]),
      .o_m0_ready(m0_ready[k]), .o_m0_rvalid(m0_rvalid[k]), .o_m0_rdata(m0_rdata[k]),
      .i_m1_req(m1_req[k]), .i_m1_write(m1_write[k]), .i_m1_addr(m1_addr[k]),
      .i_m1_byteen(m1_be[k]), .i_m1_wdata(m1_wdata[k]),
      .o_m1_ready(m1_ready[k]), .o_m1_rvalid(m1_rvalid[k]), .o_m1_rdata(m1_rdata[k]),
      .o_ram_address(ram_address[k]), .o_ram_byteena(ram_byteena[k]),
      .o_ram_wren(ram_wren[k]), .o_ram_data(ram_data[k]), .i_ram_q(ram_q[k])
    );

    always @(posedge clk) begin
      if (ram_wren[k])
        mem[ram_address[k]] <= merge(mem[ram_address[k]] ^ init_word(k, ram_address[k]),
                                     ram_data[k], ram_byteena[k]) ^ init_word(k, ram_address[k]);
      pipe[0] <= mem[ram_address[k]] ^ init_word(k, ram_address[k]);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_q[k] = pipe[L-1];
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting at t=%0t", name, $time);
  endtask

  function automatic logic rdy(int k, int p);
    return (p != 0) ? m1_ready[k] : m0_ready[k];
  endfunction
  function automatic logic rv(int k, int p);
    return (p != 0) ? m1_rvalid[k] : m0_rvalid[k];
  endfunction
  function automatic logic [31:0] rdat(int k, int p);
    return (p != 0) ? m1_rdata[k] : m0_rdata[k];
  endfunction

  // ---------------- requester queues (index = k*2+p) ----------------
  logic        t_w[6][32];
  logic [9:0]  t_a[6][32];
  logic [3:0]  t_be[6][32];
  logic [31:0] t_d[6][32];
  int head[6];
  int tail[6];

  task automatic push(int k, int p, logic w, logic [9:0] a, logic [3:0] be, logic [31:0] d);
    int i;
    i = k * 2 + p;
    t_w[i][tail[i]] = w;  t_a[i][tail[i]] = a;
    t_be[i][tail[i]] = be; t_d[i][tail[i]] = d;
    tail[i]++;
  endtask

  // driver: holds each request until its ready, then presents the next one
  initial begin
    int k, p, j;
    for (int i = 0; i < 3; i++) begin
      m0_req[i] = 0; m0_write[i] = 0; m0_addr[i] = 0; m0_be[i] = 0; m0_wdata[i] = 0;
      m1_req[i] = 0; m1_write[i] = 0; m1_addr[i] = 0; m1_be[i] = 0; m1_wdata[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        k = i / 2;
        p = i % 2;
        if (rdy(k, p) && head[i] < tail[i]) head[i]++;
        j = head[i];
        if (p == 0) begin
          m0_req[k] = (j < tail[i]);
          if (j < tail[i]) begin
            m0_write[k] = t_w[i][j]; m0_addr[k] = t_a[i][j];
            m0_be[k] = t_be[i][j];   m0_wdata[k] = t_d[i][j];
          end
        end else begin
          m1_req[k] = (j < tail[i]);
          if (j < tail[i]) begin
            m1_write[k] = t_w[i][j]; m1_addr[k] = t_a[i][j];
            m1_be[k] = t_be[i][j];   m1_wdata[k] = t_d[i][j];
          end
        end
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  int          cyc;
  int          free_at[3];
  int          last[3];
  bit          e_rdy[3][2][8];
  bit          e_rv[3][2][8];
  bit          e_wren[3][8];
  logic [31:0] e_rd[3][2][8];
  logic [9:0]  ex_addr[3];
  logic [3:0]  ex_be[3];
  logic [31:0] ex_data[3];
  logic [31:0] ex_rdata[3][2];
  logic [31:0] rmem[3][1024];
  int          gl[3][32];
  int          gn[3];

  // decide what the arbiter does with the inputs of the cycle that just ended
  task automatic model_step(int k);
    int lat, w, s;
    logic wr;
    logic [9:0] a;
    logic [3:0] be;
    logic [31:0] d;
    lat = (k == 2) ? 3 : 1;
    if (!rst_n) begin
      for (int x = 0; x < 8; x++) begin
        e_wren[k][x] = 0;
        for (int q = 0; q < 2; q++) begin e_rdy[k][q][x] = 0; e_rv[k][q][x] = 0; end
      end
      free_at[k] = cyc + 1;
      last[k] = 1;
      ex_addr[k] = 0; ex_be[k] = 0; ex_data[k] = 0;
      ex_rdata[k][0] = 0; ex_rdata[k][1] = 0;
    end else if (cyc >= free_at[k] && (m0_req[k] || m1_req[k])) begin
      if (k == 1)                       w = m0_req[k] ? 0 : 1;
      else if (m0_req[k] && m1_req[k])  w = 1 - last[k];
      else                              w = m0_req[k] ? 0 : 1;
      last[k] = w;
      if (gn[k] < 32) begin gl[k][gn[k]] = w; gn[k]++; end
      wr = (w != 0) ? m1_write[k] : m0_write[k];
      a  = (w != 0) ? m1_addr[k]  : m0_addr[k];
      be = (w != 0) ? m1_be[k]    : m0_be[k];
      d  = (w != 0) ? m1_wdata[k] : m0_wdata[k];
      s = (cyc + 1) & 7;
      e_rdy[k][w][s] = 1;
      e_wren[k][s] = wr;
      ex_addr[k] = a;
      ex_be[k] = be;
      ex_data[k] = wr ? d : 32'h0;
      if (wr) begin
        rmem[k][a] = merge(rmem[k][a], d, be);
        free_at[k] = cyc + 2;
      end else begin
        s = (cyc + 2 + lat) & 7;
        e_rv[k][w][s] = 1;
        e_rd[k][w][s] = rmem[k][a];
        free_at[k] = cyc + 2 + lat;
      end
    end
  endtask

  task automatic compare(int k);
    int s;
    s = cyc & 7;
    for (int p = 0; p < 2; p++) if (e_rv[k][p][s]) ex_rdata[k][p] = e_rd[k][p][s];
    chk($sformatf("d%0d m0_ready", k),  32'(m0_ready[k]),  32'(e_rdy[k][0][s]));
    chk($sformatf("d%0d m1_ready", k),  32'(m1_ready[k]),  32'(e_rdy[k][1][s]));
    chk($sformatf("d%0d m0_rvalid", k), 32'(m0_rvalid[k]), 32'(e_rv[k][0][s]));
    chk($sformatf("d%0d m1_rvalid", k), 32'(m1_rvalid[k]), 32'(e_rv[k][1][s]));
    chk($sformatf("d%0d ram_wren", k),  32'(ram_wren[k]),  32'(e_wren[k][s]));
    chk($sformatf("d%0d ram_address", k), 32'(ram_address[k]), 32'(ex_addr[k]));
    chk($sformatf("d%0d ram_byteena", k), 32'(ram_byteena[k]), 32'(ex_be[k]));
    chk($sformatf("d%0d ram_data", k), ram_data[k], ex_data[k]);
    chk($sformatf("d%0d m0_rdata", k), m0_rdata[k], ex_rdata[k][0]);
    chk($sformatf("d%0d m1_rdata", k), m1_rdata[k], ex_rdata[k][1]);
    e_wren[k][s] = 0;
    for (int p = 0; p < 2; p++) begin e_rdy[k][p][s] = 0; e_rv[k][p][s] = 0; end
  endtask

  // per-cycle compare process: step the model at the edge, check outputs 1 time unit later
  initial begin
    cyc = 0;
    for (int k = 0; k < 3; k++) begin
      free_at[k] = 0; last[k] = 1; gn[k] = 0;
      ex_addr[k] = 0; ex_be[k] = 0; ex_data[k] = 0;
      ex_rdata[k][0] = 0; ex_rdata[k][1] = 0;
      for (int a = 0; a < 1024; a++) rmem[k][a] = init_word(k, 10'(a));
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_step(k);
      cyc++;
      #1;
      for (int k = 0; k < 3; k++) compare(k);
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic wait_idle(string name);
    bit done;
    done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      done = 1;
      for (int i = 0; i < 6; i++) if (head[i] != tail[i]) done = 0;
      for (int k = 0; k < 3; k++) if (free_at[k] > cyc) done = 0;
    end
    if (!done) tmo(name);
  endtask

  task automatic wait_ready(int k, int p, string name, output bit ok);
    ok = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (rdy(k, p)) ok = 1;
    end
    if (!ok) tmo(name);
  endtask

  task automatic run_read(int k, int p, logic [9:0] a, output int lat, output logic [31:0] d);
    bit ok;
    lat = -1;
    d = 32'h0;
    push(k, p, 1'b0, a, 4'hF, 32'h0);
    wait_ready(k, p, "read ready", ok);
    if (ok) begin
      ok = 0;
      for (int n = 1; n <= 10 && !ok; n++) begin
        @(negedge clk);
        if (rv(k, p)) begin ok = 1; lat = n; d = rdat(k, p); end
      end
      if (!ok) tmo("read rvalid");
    end
  endtask

  task automatic run_write(int k, int p, logic [9:0] a, logic [3:0] be, logic [31:0] d);
    bit ok;
    push(k, p, 1'b1, a, be, d);
    wait_ready(k, p, "write ready", ok);
    if (ok) begin
      chk("wr wren at ready", 32'(ram_wren[k]), 32'd1);
      chk("wr address", 32'(ram_address[k]), 32'(a));
      chk("wr data", ram_data[k], d);
      chk("wr byteena", 32'(ram_byteena[k]), 32'(be));
      @(negedge clk);
      chk("wr wren drop", 32'(ram_wren[k]), 32'd0);
    end
  endtask

  initial begin
    int lat, nrv;
    bit ok;
    logic [31:0] d;
    int exp0[8];
    int exp1[8];
    exp0 = '{0, 1, 0, 1, 0, 1, 0, 1};
    exp1 = '{0, 0, 0, 0, 1, 1, 1, 1};
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin head[i] = 0; tail[i] = 0; end

    // reset with both requests pending on d0
    push(0, 0, 1'b0, 10'h010, 4'hF, 32'h0);
    push(0, 1, 1'b0, 10'h011, 4'hF, 32'h0);
    repeat (3) @(negedge clk);
    chk("reset m0_ready", 32'(m0_ready[0]), 32'd0);
    chk("reset m1_ready", 32'(m1_ready[0]), 32'd0);
    chk("reset ram_wren", 32'(ram_wren[0]), 32'd0);
    chk("reset ram_address", 32'(ram_address[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first grant m0_ready", 32'(m0_ready[0]), 32'd1);
    chk("first grant m1_ready", 32'(m1_ready[0]), 32'd0);
    wait_idle("post-reset reads");
    chk("grant order 0", 32'(gl[0][0]), 32'd0);
    chk("grant order 1", 32'(gl[0][1]), 32'd1);

    // port 0 write then read back
    run_write(0, 0, 10'h005, 4'hF, 32'hDEADBEEF);
    run_read(0, 0, 10'h005, lat, d);
    chk("rd latency d0", 32'(lat), 32'd2);
    chk("rd data DEADBEEF", d, 32'hDEADBEEF);

    // byte-lane write
    run_write(0, 0, 10'h005, 4'h2, 32'h0000AB00);
    run_read(0, 0, 10'h005, lat, d);
    chk("byte write data", d, 32'hDEADABEF);

    // contention on d0 (round-robin) and d1 (fixed priority), fresh arbitration history
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gn[0] = 0;
    gn[1] = 0;
    for (int j = 0; j < 4; j++) begin
      push(0, 0, 1'b0, 10'(j), 4'hF, 32'h0);
      push(0, 1, 1'b0, 10'(10'h100 + j), 4'hF, 32'h0);
      push(1, 0, 1'b0, 10'(j), 4'hF, 32'h0);
      push(1, 1, 1'b0, 10'(10'h100 + j), 4'hF, 32'h0);
    end
    wait_idle("contention");
    chk("d0 grant count", 32'(gn[0]), 32'd8);
    chk("d1 grant count", 32'(gn[1]), 32'd8);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("d0 rr grant %0d", j), 32'(gl[0][j]), 32'(exp0[j]));
      chk($sformatf("d1 fixed grant %0d", j), 32'(gl[1][j]), 32'(exp1[j]));
    end
    chk("d0 last m0_rdata", m0_rdata[0], 32'h01C30003);
    chk("d0 last m1_rdata", m1_rdata[0], 32'h01C30103);
    chk("d1 last m1_rdata", m1_rdata[1], 32'h02C30103);

    // latency 3 instance
    run_read(2, 0, 10'h020, lat, d);
    chk("rd latency d2", 32'(lat), 32'd4);
    chk("rd data d2", d, 32'h03C30020);

    // reset while d2 is waiting on RAM data
    push(2, 1, 1'b0, 10'h021, 4'hF, 32'h0);
    wait_ready(2, 1, "abort ready", ok);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nrv = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (m0_rvalid[2] || m1_rvalid[2]) nrv++;
    end
    chk("no rvalid after abort", 32'(nrv), 32'd0);
    run_read(2, 1, 10'h022, lat, d);
    chk("rd latency after abort", 32'(lat), 32'd4);
    chk("rd data after abort", d, 32'h03C30022);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
